wb_mem_arbiter: RTL and testbench

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/wb_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter for a shared memory slave: m0 = CPU data, m1 = Ethernet DMA.
// Define WB_MEM_ARBITER_TIMEOUT_EN to add the stalled-slave timeout error.
module wb_mem_arbiter #(
    parameter int unsigned ADR_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,

    input  logic [ADR_WIDTH-1:0] m0_adr_i,
    input  logic [31:0]          m0_dat_i,
    output logic [31:0]          m0_dat_o,
    input  logic [3:0]           m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic [ADR_WIDTH-1:0] m1_adr_i,
    input  logic [31:0]          m1_dat_i,
    output logic [31:0]          m1_dat_o,
    input  logic [3:0]           m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,

    output logic [1:0]           grant_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    state_e state_q;
    logic   last_owner_q;
    logic   own0, own1;
    logic   own_cyc, own_stb;
    logic   to_fire;
    logic   term_err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // On a tie, m0 wins unless it was the last owner.
                    if (m0_cyc_i && (!m1_cyc_i || last_owner_q)) begin
                        state_q      <= StOwn0;
                        last_owner_q <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state_q      <= StOwn1;
                        last_owner_q <= 1'b1;
                    end
                end
                StOwn0: if (!m0_cyc_i) state_q <= StIdle;
                StOwn1: if (!m1_cyc_i) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign own0    = (state_q == StOwn0);
    assign own1    = (state_q == StOwn1);
    assign grant_o = state_q;

    always_comb begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        if (own1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
        end else if (own0) begin
            own_cyc = m0_cyc_i;
            own_stb = m0_stb_i;
        end
    end

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
    localparam logic [7:0] ToLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt_q;
    logic       stall;

    assign stall   = own_stb && !s_ack_i && !s_err_i;
    // Fires during the TIMEOUT_CYCLES-th consecutive stall cycle.
    assign to_fire = stall && (to_cnt_q == ToLast);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            to_cnt_q <= 8'd0;
        end else if (state_q == StIdle || s_ack_i || s_err_i || to_fire) begin
            to_cnt_q <= 8'd0;
        end else if (stall) begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    assign s_cyc_o  = own_cyc;
    assign s_stb_o  = own_stb && !to_fire;
    assign term_err = s_err_i || to_fire;

    assign m0_ack_o = own0 && s_ack_i;
    assign m1_ack_o = own1 && s_ack_i;
    assign m0_err_o = own0 && term_err;
    assign m1_err_o = own1 && term_err;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboard bench for wb_mem_arbiter: behavioural slave acks 2 cycles after strobe.
module tb_wb_mem_arbiter;

    localparam int AckDelay = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [31:0] m0_adr, m0_dat_w, m0_dat_r, m1_adr, m1_dat_w, m1_dat_r;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
    logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb, s_ack, s_err;
    logic [1:0]  grant;

    logic        sl_ack_q, inj_ack, inj_err, sl_hang;
    int          sl_cnt;

    assign s_ack = sl_ack_q | inj_ack;
    assign s_err = inj_err;

    wb_mem_arbiter #(.ADR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk),      .wb_rst_n_i(rst_n),
        .m0_adr_i(m0_adr),   .m0_dat_i(m0_dat_w), .m0_dat_o(m0_dat_r), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we),     .m0_cyc_i(m0_cyc),   .m0_stb_i(m0_stb),
        .m0_ack_o(m0_ack),   .m0_err_o(m0_err),
        .m1_adr_i(m1_adr),   .m1_dat_i(m1_dat_w), .m1_dat_o(m1_dat_r), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we),     .m1_cyc_i(m1_cyc),   .m1_stb_i(m1_stb),
        .m1_ack_o(m1_ack),   .m1_err_o(m1_err),
        .s_adr_o(s_adr),     .s_dat_o(s_dat_w),   .s_sel_o(s_sel),     .s_we_o(s_we),
        .s_cyc_o(s_cyc),     .s_stb_o(s_stb),     .s_dat_i(s_dat_r),
        .s_ack_i(s_ack),     .s_err_i(s_err),     .grant_o(grant)
    );

    function automatic logic [31:0] rd_val(input logic [31:0] adr);
        return 32'hDEADBEEF ^ adr;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_ack_q <= 1'b0;
            sl_cnt   <= 0;
            s_dat_r  <= 32'h0;
        end else if (s_cyc && s_stb && !sl_ack_q && !sl_hang) begin
            if (sl_cnt == AckDelay - 1) begin
                sl_ack_q <= 1'b1;
                sl_cnt   <= 0;
                s_dat_r  <= s_we ? 32'h0 : rd_val(s_adr);
            end else begin
                sl_cnt <= sl_cnt + 1;
            end
        end else begin
            sl_ack_q <= 1'b0;
            if (!s_stb) sl_cnt <= 0;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_ack0 = 0;
    int   n_ack1 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_ack) begin
                n_ack0++;
                check("m0_ack_owner", 32'(grant), 32'd1);
                check("m0_sb_nonempty", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    e0 = q0.pop_front();
                    if (e0.chk_dat) check("m0_rdata", m0_dat_r, e0.dat);
                end
            end
            if (m1_ack) begin
                n_ack1++;
                check("m1_ack_owner", 32'(grant), 32'd2);
                check("m1_sb_nonempty", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    if (e1.chk_dat) check("m1_rdata", m1_dat_r, e1.dat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drv(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat_w = dat; m0_sel = 4'hF;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat_w = dat; m1_sel = 4'hF;
        end
    endtask

    task automatic wait_ack(input int m, input int bound, output int n);
        logic a;
        n = 0;
        do begin
            at_neg();
            n++;
            a = (m == 0) ? m0_ack : m1_ack;
        end while (!a && n < bound);
        check($sformatf("m%0d_ack_seen", m), 32'(a), 32'd1);
    endtask

    task automatic pulse_reset();
        at_neg();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, errs, base0;
        logic [31:0] adr;
        rst_n = 1'b1;
        inj_ack = 1'b0; inj_err = 1'b0; sl_hang = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_cyc_stb", 32'({s_cyc, s_stb}), 32'd0);
        check("rst_ack_err", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("post_rst_idle", 32'(grant), 32'd0);
        end

        // Simultaneous requests, three rounds: round robin 01, 10, 01.
        for (int r = 0; r < 3; r++) begin
            int          w;
            logic [31:0] a0, a1;
            w  = (r == 1) ? 1 : 0;
            a0 = 32'(4 * r);
            a1 = 32'(4 * r + 32'h100);
            tick();
            drv(0, 1, 1, 0, a0, 0);
            drv(1, 1, 1, 0, a1, 0);
            if (w == 0) q0.push_back('{1'b1, rd_val(a0)});
            else        q1.push_back('{1'b1, rd_val(a1)});
            at_neg();
            check("tie_idle_gap", 32'(grant), 32'd0);
            at_neg();
            check("tie_grant", 32'(grant), (w == 0) ? 32'd1 : 32'd2);
            check("tie_s_adr", s_adr, (w == 0) ? a0 : a1);
            wait_ack(w, 20, n);
            check("tie_ack_lat", 32'(n), 32'd2);
            tick();
            drv(0, 0, 0, 0, 0, 0);
            drv(1, 0, 0, 0, 0, 0);
        end
        at_neg();

        // m0 single read of 32'hDEADBEEF.
        tick();
        drv(0, 1, 1, 0, 32'h0, 0);
        q0.push_back('{1'b1, 32'hDEADBEEF});
        at_neg();
        check("rd_pre_grant", 32'({grant, s_cyc}), 32'd0);
        at_neg();
        check("rd_grant", 32'(grant), 32'd1);
        check("rd_s_cyc_stb", 32'({s_cyc, s_stb}), 32'd3);
        wait_ack(0, 20, n);
        check("rd_ack_lat", 32'(n), 32'd2);
        check("rd_m1_ack_quiet", 32'(m1_ack), 32'd0);
        check("rd_dat_direct", m0_dat_r, 32'hDEADBEEF);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        at_neg();
        check("rd_ack_pulse", 32'(m0_ack), 32'd0);
        check("rd_s_cyc_drop", 32'(s_cyc), 32'd0);
        at_neg();
        check("rd_back_idle", 32'(grant), 32'd0);

        // m1 locks the bus across four write strobes while m0 waits.
        tick();
        drv(1, 1, 1, 1, 32'h40, 32'h1111_0000);
        q1.push_back('{1'b0, 32'h0});
        at_neg();
        tick();
        drv(0, 1, 1, 0, 32'h8, 0);
        q0.push_back('{1'b1, rd_val(32'h8)});
        base0 = n_ack0;
        at_neg();
        check("lock_grant", 32'(grant), 32'd2);
        check("lock_s_dat", s_dat_w, 32'h1111_0000);
        check("lock_s_we", 32'(s_we), 32'd1);
        for (int k = 0; k < 4; k++) begin
            wait_ack(1, 20, n);
            tick();
            if (k < 3) begin
                drv(1, 1, 0, 1, 32'h40, 32'h0);
                at_neg();
                check("lock_hold", 32'(grant), 32'd2);
                tick();
                drv(1, 1, 1, 1, 32'(32'h44 + 4 * k), 32'(32'h1111_0001 + k));
                q1.push_back('{1'b0, 32'h0});
                at_neg();
                check("lock_s_dat", s_dat_w, 32'(32'h1111_0001 + k));
            end else begin
                drv(1, 0, 0, 0, 0, 0);
            end
        end
        at_neg();
        check("lock_no_m0_ack", 32'(n_ack0 - base0), 32'd0);
        at_neg();
        check("lock_release_idle", 32'(grant), 32'd0);
        at_neg();
        check("lock_m0_grant", 32'(grant), 32'd1);
        wait_ack(0, 20, n);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        at_neg();
        at_neg();

        // Slave response in IDLE goes nowhere.
        tick();
        inj_ack = 1'b1;
        inj_err = 1'b1;
        at_neg();
        check("idle_resp_dropped", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        tick();
        inj_ack = 1'b0;
        inj_err = 1'b0;

        // s_err routing and asynchronous reset while m1 owns.
        sl_hang = 1'b1;
        drv(1, 1, 1, 0, 32'h80, 0);
        at_neg();
        at_neg();
        check("err_grant", 32'(grant), 32'd2);
        tick();
        inj_err = 1'b1;
        at_neg();
        check("err_route", 32'({m0_err, m1_err}), 32'd1);
        tick();
        inj_err = 1'b0;
        at_neg();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_s_cyc_stb", 32'({s_cyc, s_stb}), 32'd0);
        check("async_rst_ack_err", 32'({m1_ack, m1_err}), 32'd0);
        drv(1, 0, 0, 0, 0, 0);
        sl_hang = 1'b0;
        tick();
        rst_n = 1'b1;
        at_neg();
        check("rst_release_idle", 32'(grant), 32'd0);

        // Reset restores last_owner=1: m0 owns last, reset, then a tie goes to m0.
        tick();
        drv(0, 1, 1, 0, 32'h10, 0);
        q0.push_back('{1'b1, rd_val(32'h10)});
        wait_ack(0, 20, n);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        at_neg();
        pulse_reset();
        drv(0, 1, 1, 0, 32'h14, 0);
        drv(1, 1, 1, 0, 32'h114, 0);
        q0.push_back('{1'b1, rd_val(32'h14)});
        at_neg();
        at_neg();
        check("rst_last_owner_tie", 32'(grant), 32'd1);
        wait_ack(0, 20, n);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        at_neg();
        at_neg();

        // Stalled slave.
        tick();
        sl_hang = 1'b1;
        drv(0, 1, 1, 0, 32'hC0, 0);
        at_neg();
        at_neg();
        check("stall_grant", 32'(grant), 32'd1);
`ifdef WB_MEM_ARBITER_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) at_neg();
            check($sformatf("to_err_c%0d", k), 32'(m0_err), 32'(k == 8));
            check($sformatf("to_stb_c%0d", k), 32'(s_stb), 32'(k != 8));
            check("to_no_ack", 32'(m0_ack), 32'd0);
        end
        tick();
        drv(0, 0, 0, 0, 0, 0);
        at_neg();
        check("to_err_single", 32'(m0_err), 32'd0);
`else
        errs = 0;
        for (int k = 0; k < 300; k++) begin
            at_neg();
            if (m0_err || m0_ack) errs++;
        end
        check("stall_no_err", 32'(errs), 32'd0);
        check("stall_still_owned", 32'(grant), 32'd1);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        at_neg();
`endif
        sl_hang = 1'b0;
        at_neg();
        check("stall_back_idle", 32'(grant), 32'd0);
        check("sb_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
